// File: rtl/medication_scheduler_if.sv
// Bus between the RTC/LED side and medication_scheduler: tick, buttons,
// schedule configuration and the alarm/miss outputs.
interface medication_scheduler_if #(
  parameter int N  = 4,
  parameter int TW = 5,
  parameter int CW = 4
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;

  logic            tick;
  logic [N-1:0]    button;
  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic [TW-1:0]   cfg_time;
  logic            miss_clr;
  logic [TW-1:0]   cur_time;
  logic [N-1:0]    shouldEat;
  logic [N-1:0]    notify;
  logic [N*CW-1:0] miss_cnt;

  modport master (
    output tick, button, cfg_we, cfg_ch, cfg_time, miss_clr,
    input  cur_time, shouldEat, notify, miss_cnt
  );

  modport slave (
    input  tick, button, cfg_we, cfg_ch, cfg_time, miss_clr,
    output cur_time, shouldEat, notify, miss_cnt
  );
endinterface

// File: rtl/medication_scheduler.sv
// Multi-channel dose scheduler: time-of-day counter, per-channel dose alarms,
// grace-window expiry with saturating miss counters. MED_SNOOZE_EN adds one re-alarm.
module medication_scheduler #(
  parameter int N     = 4,
  parameter int DAY   = 24,
  parameter int TW    = 5,
  parameter int GRACE = 3,
  parameter int CW    = 4
) (
  input logic                   clk,
  input logic                   rst,
  medication_scheduler_if.slave bus
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam int AW  = (GRACE > 1) ? $clog2(GRACE) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DUE    = 2'd1;
  localparam logic [1:0] S_NOTIFY = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [TW-1:0]   r_curTime;
  logic [TW-1:0]   w_nextTime;
  logic [TW-1:0]   r_sched [N];
  logic [1:0]      r_state [N];
  logic [AW-1:0]   r_age   [N];
  logic [N-1:0]    w_hit;
  logic [N-1:0]    r_shouldEat;
  logic [N-1:0]    r_notify;
  logic [N*CW-1:0] r_missCnt;
`ifdef MED_SNOOZE_EN
  logic [N-1:0]    r_snoozed;
`endif

  // Disabled channels hold a value >= DAY, which w_nextTime can never reach.
  always_comb begin
    w_nextTime = (r_curTime == TW'(DAY - 1)) ? '0 : r_curTime + 1'b1;
    for (int i = 0; i < N; i++) begin
      w_hit[i] = bus.tick && (w_nextTime == r_sched[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_curTime <= '0;
    end else if (bus.tick) begin
      r_curTime <= w_nextTime;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_sched[i] <= '1;
    end else if (bus.cfg_we) begin
      for (int i = 0; i < N; i++) begin
        if (bus.cfg_ch == CHW'(i)) r_sched[i] <= bus.cfg_time;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        r_state[i] <= S_IDLE;
        r_age[i]   <= '0;
      end
      r_shouldEat <= '0;
      r_notify    <= '0;
      r_missCnt   <= '0;
`ifdef MED_SNOOZE_EN
      r_snoozed   <= '0;
`endif
    end else begin
      r_notify <= '0;
      for (int i = 0; i < N; i++) begin
        case (r_state[i])
          S_IDLE, S_NOTIFY: begin
            r_state[i] <= S_IDLE;
            if (w_hit[i]) begin
              r_state[i]     <= S_DUE;
              r_shouldEat[i] <= 1'b1;
              r_age[i]       <= '0;
`ifdef MED_SNOOZE_EN
              r_snoozed[i]   <= 1'b0;
`endif
            end
          end
          S_DUE: begin
            if (bus.button[i]) begin
              r_state[i]     <= S_IDLE;
              r_shouldEat[i] <= 1'b0;
            end else if (bus.tick) begin
              if (r_age[i] == AW'(GRACE - 1)) begin
                r_notify[i] <= 1'b1;
`ifdef MED_SNOOZE_EN
                if (!r_snoozed[i]) begin
                  r_snoozed[i] <= 1'b1;
                  r_age[i]     <= '0;
                end else begin
                  r_state[i]     <= S_NOTIFY;
                  r_shouldEat[i] <= 1'b0;
                  if (r_missCnt[i*CW +: CW] != CNT_MAX)
                    r_missCnt[i*CW +: CW] <= r_missCnt[i*CW +: CW] + 1'b1;
                end
`else
                r_state[i]     <= S_NOTIFY;
                r_shouldEat[i] <= 1'b0;
                if (r_missCnt[i*CW +: CW] != CNT_MAX)
                  r_missCnt[i*CW +: CW] <= r_missCnt[i*CW +: CW] + 1'b1;
`endif
              end else begin
                r_age[i] <= r_age[i] + 1'b1;
              end
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
      // Placed last so a clear overrides any same-cycle increment.
      if (bus.miss_clr) r_missCnt <= '0;
    end
  end

  assign bus.cur_time  = r_curTime;
  assign bus.shouldEat = r_shouldEat;
  assign bus.notify    = r_notify;
  assign bus.miss_cnt  = r_missCnt;
endmodule
